line_window3x3: RTL and testbench



---
 rtl/line_window3x3.sv | 149 ++++++++++++++
 tb/tb_line_window3x3.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_window3x3.sv
// -----------------------------------------------------------------------------
// line_window3x3
//   Streaming 3x3 sliding-window generator feeding the 3x3 filter stage.
//   Pixels arrive one per accepted cycle in raster order. The previous two
//   rows are held in line buffers, and each interior position produces a full
//   3x3 neighbourhood one cycle after its bottom-right pixel is accepted.
//
//   Optional build macro: WIN_STRIDE2_EN
//     When defined, windows are emitted only where out_row and out_col are
//     both even. Line buffers and window registers still update on every
//     accepted pixel, and frame_done is unaffected.
//
// Parameters
//   DW     pixel width (two's complement; carried through unmodified)
//   IMG_W  image width  (>= 3)
//   IMG_H  image height (>= 3)
//
// Ports
//   clk         clock
//   resetn      asynchronous active-low reset
//   in_valid    pixel-present qualifier (gaps allowed, no backpressure)
//   in_sof      start of frame; the accepted pixel becomes position (0,0)
//   in_data     pixel value
//   out_valid   one-cycle pulse when win holds a new window
//   win         window; element (col j, row i) at [(i*3+j)*DW +: DW],
//               row 0 = top (oldest), col 0 = leftmost
//   out_row     top-left row of the window
//   out_col     top-left column of the window
//   frame_done  one-cycle pulse after the last pixel of a frame is accepted
// -----------------------------------------------------------------------------
module line_window3x3 #(
  parameter int DW    = 10,
  parameter int IMG_W = 32,
  parameter int IMG_H = 32
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       in_valid,
  input  logic                       in_sof,
  input  logic [DW-1:0]              in_data,
  output logic                       out_valid,
  output logic [9*DW-1:0]            win,
  output logic [$clog2(IMG_H)-1:0]   out_row,
  output logic [$clog2(IMG_W)-1:0]   out_col,
  output logic                       frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  // Line buffers: r_lb0 holds the row above the current one, r_lb1 the row
  // above that.
  logic [DW-1:0] r_lb0 [IMG_W];
  logic [DW-1:0] r_lb1 [IMG_W];

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;

  // Middle and right window columns (index = window row). The left column is
  // only needed at the moment a window is emitted, so it is taken straight
  // from r_win_c1 into the output register.
  logic [DW-1:0] r_win_c1 [3];
  logic [DW-1:0] r_win_c2 [3];

  logic [CW-1:0] w_col;
  logic [RW-1:0] w_row;
  logic [DW-1:0] w_new [3];
  logic          w_win_ok;
  logic          w_last;

  // SOF forces the accepted pixel to (0,0) whatever the counters say.
  assign w_col = in_sof ? '0 : r_col;
  assign w_row = in_sof ? '0 : r_row;

  // Newest column, top to bottom: two rows up, one row up, current pixel.
  assign w_new[0] = r_lb1[w_col];
  assign w_new[1] = r_lb0[w_col];
  assign w_new[2] = in_data;

  // Rows 0/1 and cols 0/1 are masked so stale line-buffer contents and the
  // previous row's tail in the window registers never reach the output.
`ifdef WIN_STRIDE2_EN
  // out_row = row-2 and out_col = col-2 share parity with row and col.
  assign w_win_ok = in_valid && (w_row >= RW'(2)) && (w_col >= CW'(2))
                    && !w_row[0] && !w_col[0];
`else
  assign w_win_ok = in_valid && (w_row >= RW'(2)) && (w_col >= CW'(2));
`endif

  assign w_last = in_valid && (w_row == ROW_LAST) && (w_col == COL_LAST);

  // NOTE: line-buffer memories carry no reset; their stale contents are
  // masked by the row/col validity rule, and a reset would prevent RAM
  // inference. Non-blocking writes give read-before-write: w_new sees the
  // old r_lb0/r_lb1 entries in the same cycle they are overwritten.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      r_lb1[w_col] <= r_lb0[w_col];
      r_lb0[w_col] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_col      <= '0;
      r_row      <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      win        <= '0;
      out_row    <= '0;
      out_col    <= '0;
      for (int i = 0; i < 3; i++) begin
        r_win_c1[i] <= '0;
        r_win_c2[i] <= '0;
      end
    end else begin
      out_valid  <= w_win_ok;
      frame_done <= w_last;

      if (in_valid) begin
        if (w_col == COL_LAST) begin
          r_col <= '0;
          r_row <= (w_row == ROW_LAST) ? '0 : w_row + RW'(1);
        end else begin
          r_col <= w_col + CW'(1);
          r_row <= w_row;
        end
        for (int i = 0; i < 3; i++) begin
          r_win_c1[i] <= r_win_c2[i];
          r_win_c2[i] <= w_new[i];
        end
      end

      // Output window is captured only on a valid window and holds otherwise.
      if (w_win_ok) begin
        for (int i = 0; i < 3; i++) begin
          win[(i*3+0)*DW +: DW] <= r_win_c1[i];
          win[(i*3+1)*DW +: DW] <= r_win_c2[i];
          win[(i*3+2)*DW +: DW] <= w_new[i];
        end
        out_row <= w_row - RW'(2);
        out_col <= w_col - CW'(2);
      end
    end
  end

endmodule

// File: tb/tb_line_window3x3.sv
// -----------------------------------------------------------------------------
// tb_line_window3x3
//   Self-checking bench for line_window3x3. A frame-array reference model
//   records every accepted pixel at its (row,col) and forms each expected
//   window directly from the 3x3 neighbourhood of the image. Build with
//   WIN_STRIDE2_EN defined to exercise the stride-2 variant on a 7x6 image.
// -----------------------------------------------------------------------------
module tb_line_window3x3;

  localparam int DW = 10;
`ifdef WIN_STRIDE2_EN
  localparam int W      = 7;
  localparam int H      = 6;
  localparam bit STRIDE = 1'b1;
`else
  localparam int W      = 5;
  localparam int H      = 4;
  localparam bit STRIDE = 1'b0;
`endif
  localparam int CW = $clog2(W);
  localparam int RW = $clog2(H);
  localparam int WW = 9 * DW;

  // Windows per complete frame and top-left of the last one.
  localparam int NWIN    = STRIDE ? ((W - 1) / 2) * ((H - 1) / 2) : (W - 2) * (H - 2);
  localparam int LAST_R  = STRIDE ? ((H - 3) / 2) * 2 : H - 3;
  localparam int LAST_C  = STRIDE ? ((W - 3) / 2) * 2 : W - 3;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_sof = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic [WW-1:0] win;
  logic [RW-1:0] out_row;
  logic [CW-1:0] out_col;
  logic          frame_done;

  line_window3x3 #(.DW(DW), .IMG_W(W), .IMG_H(H)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .in_valid   (in_valid),
    .in_sof     (in_sof),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .win        (win),
    .out_row    (out_row),
    .out_col    (out_col),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [DW-1:0] img [H][W];
  int            m_row = 0;
  int            m_col = 0;
  logic          exp_valid = 1'b0;
  logic          exp_done  = 1'b0;
  logic [WW-1:0] exp_win   = '0;
  logic [RW-1:0] exp_row   = '0;
  logic [CW-1:0] exp_col   = '0;

  // Observations per scenario.
  int            win_cnt  = 0;
  int            done_cnt = 0;
  logic [WW-1:0] obs_q [$];

  task automatic model_apply(input logic v, input logic s, input logic [DW-1:0] d);
    int r;
    int c;
    exp_valid = 1'b0;
    exp_done  = 1'b0;
    if (v) begin
      r = s ? 0 : m_row;
      c = s ? 0 : m_col;
      img[r][c] = d;
      if (r >= 2 && c >= 2 && (!STRIDE || ((r - 2) % 2 == 0 && (c - 2) % 2 == 0))) begin
        exp_valid = 1'b1;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            exp_win[(i*3+j)*DW +: DW] = img[r-2+i][c-2+j];
        exp_row = RW'(r - 2);
        exp_col = CW'(c - 2);
      end
      exp_done = (r == H - 1) && (c == W - 1);
      c++;
      if (c == W) begin
        c = 0;
        r = (r == H - 1) ? 0 : r + 1;
      end
      m_row = r;
      m_col = c;
    end
  endtask

  task automatic check_outputs();
    check("out_valid", WW'(out_valid), WW'(exp_valid));
    check("frame_done", WW'(frame_done), WW'(exp_done));
    check("win", win, exp_win);
    check("out_row", WW'(out_row), WW'(exp_row));
    check("out_col", WW'(out_col), WW'(exp_col));
    if (out_valid === 1'b1) begin
      win_cnt++;
      obs_q.push_back(win);
    end
    if (frame_done === 1'b1) done_cnt++;
  endtask

  // One cycle: check the previous cycle's effects, then drive new inputs.
  task automatic step(input logic v, input logic s, input logic [DW-1:0] d);
    @(negedge clk);
    check_outputs();
    in_valid = v;
    in_sof   = s;
    in_data  = d;
    model_apply(v, s, d);
  endtask

  task automatic flush();
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0);
  endtask

  task automatic clear_obs();
    win_cnt  = 0;
    done_cnt = 0;
    obs_q.delete();
  endtask

  // Sends the first n_pix pixels of a frame; gap_pct = idle probability in %.
  task automatic send_frame(input int base, input int n_pix, input int gap_pct, input bit rnd);
    for (int k = 0; k < n_pix; k++) begin
      int r = k / W;
      int c = k % W;
      logic [DW-1:0] pix;
      while ($urandom_range(0, 99) < gap_pct)
        step(1'b0, 1'($urandom_range(0, 1)), DW'($urandom));
      pix = rnd ? DW'($urandom) : DW'(base + r * 16 + c);
      step(1'b1, (k == 0), pix);
    end
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    check_outputs();
    resetn   = 1'b0;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    exp_valid = 1'b0;
    exp_done  = 1'b0;
    exp_win   = '0;
    exp_row   = '0;
    exp_col   = '0;
    m_row = 0;
    m_col = 0;
    #1;
    check("rst_win_async", win, '0);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      check_outputs();
    end
    resetn = 1'b1;
  endtask

  task automatic check_frame_contents(input string tag, input int idx, input int base);
    logic [WW-1:0] w;
    if (obs_q.size() <= idx) begin
      check({tag, "_missing"}, WW'(obs_q.size()), WW'(idx + 1));
    end else begin
      w = obs_q[idx];
      check({tag, "_x0_0"}, WW'(w[0*DW +: DW]), WW'(DW'(base + 0)));
      check({tag, "_x2_0"}, WW'(w[2*DW +: DW]), WW'(DW'(base + 2)));
      check({tag, "_x0_2"}, WW'(w[6*DW +: DW]), WW'(DW'(base + 32)));
      check({tag, "_x2_2"}, WW'(w[8*DW +: DW]), WW'(DW'(base + 34)));
    end
  endtask

  task automatic check_last(input string tag, input int idx, input int base);
    logic [WW-1:0] w;
    if (obs_q.size() <= idx) begin
      check({tag, "_missing"}, WW'(obs_q.size()), WW'(idx + 1));
    end else begin
      w = obs_q[idx];
      check({tag, "_x2_2"}, WW'(w[8*DW +: DW]), WW'(DW'(base + (LAST_R + 2) * 16 + LAST_C + 2)));
    end
  endtask

  initial begin
    // Reset state
    do_reset(3);
    check("rst_valid", WW'(out_valid), '0);
    check("rst_win", win, '0);

    // 1: frame without gaps
    clear_obs();
    send_frame(0, W * H, 0, 1'b0);
    flush();
    check("f1_wins", WW'(win_cnt), WW'(NWIN));
    check("f1_done", WW'(done_cnt), WW'(1));
    check_frame_contents("f1_first", 0, 0);
    check_last("f1_last", NWIN - 1, 0);

    // 2: same frame with ~30% idle cycles
    clear_obs();
    send_frame(0, W * H, 30, 1'b0);
    flush();
    check("f2_wins", WW'(win_cnt), WW'(NWIN));
    check("f2_done", WW'(done_cnt), WW'(1));
    check_frame_contents("f2_first", 0, 0);

    // 3: two back-to-back frames
    clear_obs();
    send_frame(0, W * H, 0, 1'b0);
    send_frame(100, W * H, 0, 1'b0);
    flush();
    check("b2b_wins", WW'(win_cnt), WW'(2 * NWIN));
    check("b2b_done", WW'(done_cnt), WW'(2));
    check_frame_contents("b2b_second", NWIN, 100);
    check_last("b2b_last", 2 * NWIN - 1, 100);

    // 4: mid-frame SOF at old-frame position (2,1)
    clear_obs();
    send_frame(0, 2 * W + 1, 0, 1'b0);
    send_frame(200, W * H, 20, 1'b0);
    flush();
    check("sof_wins", WW'(win_cnt), WW'(NWIN));
    check("sof_done", WW'(done_cnt), WW'(1));
    check_frame_contents("sof_first", 0, 200);

    // 5: reset while the pixel at (2,3) would be accepted
    send_frame(0, 2 * W + 3, 0, 1'b0);
    do_reset(2);
    check("rstmid_valid", WW'(out_valid), '0);
    check("rstmid_win", win, '0);
    clear_obs();
    send_frame(0, W * H, 0, 1'b0);
    flush();
    check("rstmid_wins", WW'(win_cnt), WW'(NWIN));
    check("rstmid_done", WW'(done_cnt), WW'(1));
    check_frame_contents("rstmid_first", 0, 0);

    // 6: random pixel values (including negatives) with gaps, two frames
    clear_obs();
    send_frame(0, W * H, 30, 1'b1);
    send_frame(0, W * H, 10, 1'b1);
    flush();
    check("rnd_wins", WW'(win_cnt), WW'(2 * NWIN));
    check("rnd_done", WW'(done_cnt), WW'(2));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
